register_bank: RTL and testbench

- 8-entry general-purpose register file: the consumer of the one-hot load-enable vector produced by the destination-register decoder.
- Encodes and validates the one-hot enable, performs the write, and serves two registered source-operand read ports (SR1, SR2) to the datapath/ALU.
- Includes write-to-read forwarding and a sticky error flag for illegal (multi-hot) enable vectors.

---
 rtl/register_bank.sv | 59 +++++
 tb/tb_register_bank.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: 8-entry register file with one-hot write decode, multi-hot error flag,
// write-to-read forwarding and two registered read ports.
module register_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       WE,
  input  logic [WIDTH-1:0] DIN,
  input  logic [2:0]       SR1,
  input  logic [2:0]       SR2,
  input  logic             RD_EN,
  input  logic             ERR_CLR,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  output logic             RD_VALID,
  output logic [2:0]       WR_IDX,
  output logic             WR_VALID,
  output logic             WE_ERR
);
  logic [WIDTH-1:0] regs [8];
  logic             legal;
  logic             illegal;
  logic [2:0]       idx;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  // idx is only meaningful when WE is one-hot; illegal vectors never reach the array
  always_comb begin
    illegal = |(WE & (WE - 8'd1));
    legal   = |WE && !illegal;
    idx     = {|(WE & 8'hF0), |(WE & 8'hCC), |(WE & 8'hAA)};
    val1    = (legal && idx == SR1) ? DIN : regs[SR1];
    val2    = (legal && idx == SR2) ? DIN : regs[SR2];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (legal) begin
      regs[idx] <= DIN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SR1_OUT  <= '0;
      SR2_OUT  <= '0;
      RD_VALID <= 1'b0;
      WR_IDX   <= '0;
      WR_VALID <= 1'b0;
      WE_ERR   <= 1'b0;
    end else begin
      SR1_OUT  <= RD_EN ? val1 : SR1_OUT;
      SR2_OUT  <= RD_EN ? val2 : SR2_OUT;
      RD_VALID <= RD_EN;
      WR_IDX   <= legal ? idx : WR_IDX;
      WR_VALID <= legal;
      WE_ERR   <= illegal | (WE_ERR & ~ERR_CLR);
    end
  end
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: scoreboard bench for register_bank; expected reads are queued at
// stimulus time and popped when RD_VALID appears.
module tb_register_bank;
  localparam int WIDTH = 16;
  logic             clk;
  logic             rst_n;
  logic [7:0]       WE;
  logic [WIDTH-1:0] DIN;
  logic [2:0]       SR1;
  logic [2:0]       SR2;
  logic             RD_EN;
  logic             ERR_CLR;
  logic [WIDTH-1:0] SR1_OUT;
  logic [WIDTH-1:0] SR2_OUT;
  logic             RD_VALID;
  logic [2:0]       WR_IDX;
  logic             WR_VALID;
  logic             WE_ERR;

  register_bank #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .WE(WE), .DIN(DIN), .SR1(SR1), .SR2(SR2),
    .RD_EN(RD_EN), .ERR_CLR(ERR_CLR), .SR1_OUT(SR1_OUT), .SR2_OUT(SR2_OUT),
    .RD_VALID(RD_VALID), .WR_IDX(WR_IDX), .WR_VALID(WR_VALID), .WE_ERR(WE_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0]      sb [$];
  logic [WIDTH-1:0] mdl [8];
  logic [WIDTH-1:0] hold1, hold2;
  logic             exp_rv, exp_wv, exp_err;
  logic [2:0]       exp_wi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    hold1 = '0; hold2 = '0;
    exp_rv = 0; exp_wv = 0; exp_err = 0; exp_wi = '0;
    sb.delete();
  endtask

  task automatic do_cycle(input logic [7:0] we, input logic [WIDTH-1:0] din, input logic rd,
                          input logic [2:0] s1, input logic [2:0] s2, input logic clr);
    int cnt;
    int k;
    logic [WIDTH-1:0] v1, v2;
    logic [31:0] e;
    WE = we; DIN = din; RD_EN = rd; SR1 = s1; SR2 = s2; ERR_CLR = clr;
    cnt = $countones(we);
    k = 0;
    for (int i = 0; i < 8; i++) if (we[i]) k = i;
    v1 = (cnt == 1 && k == int'(s1)) ? din : mdl[s1];
    v2 = (cnt == 1 && k == int'(s2)) ? din : mdl[s2];
    if (rd) sb.push_back({v1, v2});
    if (cnt == 1) begin
      mdl[k] = din;
      exp_wi = 3'(k);
    end
    exp_wv  = (cnt == 1);
    exp_err = (cnt > 1) ? 1'b1 : (clr ? 1'b0 : exp_err);
    exp_rv  = rd;
    @(posedge clk);
    #1;
    check("rd_valid", RD_VALID, exp_rv);
    check("wr_valid", WR_VALID, exp_wv);
    check("wr_idx", WR_IDX, exp_wi);
    check("we_err", WE_ERR, exp_err);
    if (RD_VALID) begin
      check("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        hold1 = e[31:16];
        hold2 = e[15:0];
      end
    end
    check("sr1_out", SR1_OUT, hold1);
    check("sr2_out", SR2_OUT, hold2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(8'h00, '0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    model_reset();
    rst_n = 0; WE = 0; DIN = 0; SR1 = 0; SR2 = 0; RD_EN = 0; ERR_CLR = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sr1", SR1_OUT, 0);
    check("rst_sr2", SR2_OUT, 0);
    check("rst_rv", RD_VALID, 0);
    check("rst_wi", WR_IDX, 0);
    check("rst_wv", WR_VALID, 0);
    check("rst_err", WE_ERR, 0);
    rst_n = 1;
    // read after reset, pulse must last exactly one cycle
    do_cycle(8'h00, '0, 1'b1, 3'd0, 3'd7, 1'b0);
    idle(1);
    // fill R0..R7
    for (int i = 0; i < 8; i++) do_cycle(8'(1 << i), 16'h1000 + 16'(i), 1'b0, 3'd0, 3'd0, 1'b0);
    idle(1);
    do_cycle(8'h00, '0, 1'b1, 3'd3, 3'd6, 1'b0);
    check("rd_r3", SR1_OUT, 16'h1003);
    check("rd_r6", SR2_OUT, 16'h1006);
    // forwarding
    do_cycle(8'h20, 16'hBEEF, 1'b1, 3'd5, 3'd4, 1'b0);
    check("fwd_sr1", SR1_OUT, 16'hBEEF);
    check("fwd_sr2", SR2_OUT, 16'h1004);
    do_cycle(8'h00, '0, 1'b1, 3'd5, 3'd5, 1'b0);
    check("after_fwd", SR1_OUT, 16'hBEEF);
    do_cycle(8'h04, 16'h2222, 1'b1, 3'd2, 3'd2, 1'b0);
    check("fwd_both", SR2_OUT, 16'h2222);
    // illegal WE: no write, no forward, sticky error
    do_cycle(8'h06, 16'hDEAD, 1'b1, 3'd1, 3'd2, 1'b0);
    check("ill_nofwd", SR1_OUT, 16'h1001);
    check("ill_wv", WR_VALID, 0);
    check("ill_err", WE_ERR, 1);
    idle(3);
    check("err_sticky", WE_ERR, 1);
    do_cycle(8'h18, 16'hDEAD, 1'b0, 3'd0, 3'd0, 1'b1);
    check("set_wins", WE_ERR, 1);
    do_cycle(8'h00, '0, 1'b0, 3'd0, 3'd0, 1'b1);
    check("err_clr", WE_ERR, 0);
    do_cycle(8'h00, '0, 1'b1, 3'd1, 3'd2, 1'b0);
    check("r1_kept", SR1_OUT, 16'h1001);
    check("r2_kept", SR2_OUT, 16'h2222);
    // hold while writing R3 with no read
    do_cycle(8'h00, '0, 1'b1, 3'd3, 3'd7, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(8'h08, 16'h3300 + 16'(i), 1'b0, 3'd3, 3'd3, 1'b0);
    check("hold_sr1", SR1_OUT, 16'h1003);
    do_cycle(8'h00, '0, 1'b1, 3'd3, 3'd4, 1'b0);
    check("r3_new", SR1_OUT, 16'h3303);
    // async reset between edges during a write to R7
    WE = 8'h80; DIN = 16'h7777; RD_EN = 0;
    #3;
    rst_n = 0;
    #1;
    check("arst_sr1", SR1_OUT, 0);
    check("arst_sr2", SR2_OUT, 0);
    check("arst_wv", WR_VALID, 0);
    check("arst_wi", WR_IDX, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    WE = 8'h00;
    model_reset();
    do_cycle(8'h00, '0, 1'b1, 3'd7, 3'd4, 1'b0);
    check("r7_zero", SR1_OUT, 0);
    idle(1);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
